// File: rtl/half_adder.sv
// Registered multi-lane half adder with a 1-cycle latency and an optional carry statistics counter.
// Define HALF_ADDER_STATS_EN to build carry_count/stat_clr; otherwise carry_count reads as zero.
module half_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             stat_clr,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  output logic [15:0]      carry_count
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
    $error("half_adder: WIDTH must be in 1..32");
  end

  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             out_valid_q;

  // Lanes are independent: no carry ripples between bit positions.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    if (in_valid) begin
      sum_d   = a ^ b;
      carry_d = a & b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= in_valid;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = out_valid_q;

`ifdef HALF_ADDER_STATS_EN
  logic [15:0] count_q, count_d;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    count_d = count_q;
    if (stat_clr) begin
      count_d = '0;
    end else if (in_valid && (|(a & b)) && (count_q != '1)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign carry_count = count_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign carry_count     = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed table-driven bench for half_adder: a WIDTH=1 and a WIDTH=4 instance share one stimulus stream.
module tb_half_adder;

  logic       clk;
  logic       rst;
  logic [3:0] a, b;
  logic       in_valid;
  logic       stat_clr;

  logic       sum1, carry1, ov1;
  logic [15:0] cc1;
  logic [3:0] sum4, carry4;
  logic       ov4;
  logic [15:0] cc4;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] m1, m4;
  bit          stats_on;

  half_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .a(a[0]), .b(b[0]), .in_valid(in_valid), .stat_clr(stat_clr),
    .sum(sum1), .carry(carry1), .out_valid(ov1), .carry_count(cc1)
  );

  half_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .stat_clr(stat_clr),
    .sum(sum4), .carry(carry4), .out_valid(ov4), .carry_count(cc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       v;
    logic [3:0] esum;
    logic [3:0] ecarry;
    logic       eov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference counters: model the edge using the inputs present just before it.
  task automatic tick();
    if (rst || stat_clr) begin
      m1 = '0;
      m4 = '0;
    end else if (in_valid) begin
      if ((a[0] & b[0]) && m1 != 16'hFFFF) m1 = m1 + 16'd1;
      if ((|(a & b)) && m4 != 16'hFFFF) m4 = m4 + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic v,
                       input logic r, input logic c);
    a = va; b = vb; in_valid = v; rst = r; stat_clr = c;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] es, input logic [3:0] ec, input logic eov);
    chk($sformatf("%s w4 sum", tag), {28'd0, sum4}, {28'd0, es});
    chk($sformatf("%s w4 carry", tag), {28'd0, carry4}, {28'd0, ec});
    chk($sformatf("%s w4 out_valid", tag), {31'd0, ov4}, {31'd0, eov});
    chk($sformatf("%s w1 sum", tag), {31'd0, sum1}, {31'd0, es[0]});
    chk($sformatf("%s w1 carry", tag), {31'd0, carry1}, {31'd0, ec[0]});
    chk($sformatf("%s w1 out_valid", tag), {31'd0, ov1}, {31'd0, eov});
    chk($sformatf("%s w4 carry_count", tag), {16'd0, cc4}, {16'd0, stats_on ? m4 : 16'h0});
    chk($sformatf("%s w1 carry_count", tag), {16'd0, cc1}, {16'd0, stats_on ? m1 : 16'h0});
  endtask

  vec_t vecs[9];

  initial begin
`ifdef HALF_ADDER_STATS_EN
    stats_on = 1'b1;
`else
    stats_on = 1'b0;
`endif
    m1 = '0;
    m4 = '0;
    vecs[0] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1};
    vecs[1] = '{4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1};
    vecs[2] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b1};
    vecs[3] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b1};
    vecs[4] = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b0};
    vecs[5] = '{4'b1100, 4'b1010, 1'b1, 4'b0110, 4'b1000, 1'b1};
    vecs[6] = '{4'b1111, 4'b0101, 1'b1, 4'b1010, 4'b0101, 1'b1};
    vecs[7] = '{4'b0011, 4'b1110, 1'b1, 4'b1101, 4'b0010, 1'b1};
    vecs[8] = '{4'b1111, 4'b1111, 1'b0, 4'b1101, 4'b0010, 1'b0};

    // Reset with a valid 11 presented: the operation must be discarded.
    drive(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    chk_all("reset", 4'b0000, 4'b0000, 1'b0);

    // Back-to-back table, including hold rows.
    for (int unsigned i = 0; i < 9; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].v, 1'b0, 1'b0);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].esum, vecs[i].ecarry, vecs[i].eov);
    end

    // Spaced truth table: each op followed by idle cycles that must hold.
    drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    for (int unsigned i = 0; i < 4; i++) begin
      drive({3'b000, i[1]}, {3'b000, i[0]}, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all($sformatf("tt%0d", i), {3'b000, i[1] ^ i[0]}, {3'b000, i[1] & i[0]}, 1'b1);
      drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
      for (int unsigned k = 0; k < 9; k++) tick();
      chk_all($sformatf("tt%0d idle", i), {3'b000, i[1] ^ i[0]}, {3'b000, i[1] & i[0]}, 1'b0);
    end

    // Stats: three carrying ops and two non-carrying ops.
    drive(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    drive(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk_all("stats3", 4'b1111, 4'b0000, 1'b1);
    chk("stats3 w4 count literal", {16'd0, cc4}, stats_on ? 32'd3 : 32'd0);

    // Clear beats a simultaneous carrying op; datapath still updates.
    drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("clr", 4'b0000, 4'b1111, 1'b1);
    chk("clr w4 count literal", {16'd0, cc4}, 32'd0);
    drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("post clr", 4'b0000, 4'b1111, 1'b1);

    // Mid-stream reset drops the in-flight op; first op after release appears one cycle later.
    drive(4'b0110, 4'b0011, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("mid rst", 4'b0000, 4'b0000, 1'b0);
    drive(4'b0110, 4'b0011, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("after rst", 4'b0101, 4'b0010, 1'b1);

    // Saturation: 65535 carrying ops from zero, then one more.
    drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
    tick();
    drive(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 65534; i++) tick();
    chk("sat-1 w4 count", {16'd0, cc4}, stats_on ? 32'hFFFE : 32'd0);
    tick();
    chk_all("sat", 4'b0000, 4'b1111, 1'b1);
    chk("sat w4 count literal", {16'd0, cc4}, stats_on ? 32'hFFFF : 32'd0);
    tick();
    chk_all("sat+1", 4'b0000, 4'b1111, 1'b1);
    chk("sat+1 w1 count literal", {16'd0, cc1}, stats_on ? 32'hFFFF : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the number of independent half-adder lanes (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 The block SHALL have port a, input, WIDTH, the first operand bits, one per lane.
REQ-005 The block SHALL have port b, input, WIDTH, the second operand bits, one per lane.
REQ-006 The block SHALL have port in_valid, input, 1, which qualifies a and b in the current cycle.
REQ-007 The block SHALL have port stat_clr, input, 1, a synchronous clear for carry_count.
REQ-008 The block SHALL have port sum, output, WIDTH, the registered per-lane sum.
REQ-009 The block SHALL have port carry, output, WIDTH, the registered per-lane carry.
REQ-010 The block SHALL have port out_valid, output, 1, which marks sum and carry as updated this cycle.
REQ-011 The block SHALL have port carry_count, output, 16, the saturating count of accepted operations with any carry set.

Function
REQ-012 For each lane i: sum[i] = a[i] XOR b[i] and carry[i] = a[i] AND b[i]; lanes are independent, with no carry propagation between lanes.
REQ-013 Latency SHALL be exactly 1 cycle: operands sampled on edge N with in_valid=1 appear on sum/carry after edge N, with out_valid=1 for that cycle.
REQ-014 When in_valid=0 at an edge, sum and carry SHALL hold their previous values and out_valid SHALL be 0.
REQ-015 Back-to-back valid inputs SHALL be accepted every cycle with no bubbles and no backpressure.
REQ-016 Truth table per lane (a,b -> sum,carry): 00->00, 01->10, 10->10, 11->01.
REQ-017 carry_count SHALL increment by 1 on each accepted operation (in_valid=1) where carry is non-zero, and saturate at 16'hFFFF without wrapping.
REQ-018 If stat_clr=1, carry_count SHALL become 0 at the edge, overriding a simultaneous increment; sum, carry and out_valid SHALL be unaffected.
REQ-019 X-free outputs: all outputs SHALL be driven from flops with defined reset values.

Reset
REQ-020 When rst=1 at a rising edge, sum, carry and carry_count SHALL become 0 and out_valid SHALL become 0.
REQ-021 Reset SHALL take priority over in_valid and stat_clr; an operation presented in the reset cycle is discarded.
REQ-022 Reset asserted mid-stream SHALL drop any in-flight result; the first valid input after rst deasserts SHALL produce its result 1 cycle later.

Configuration
REQ-023 Macro HALF_ADDER_STATS_EN: when defined, the carry_count counter and stat_clr logic SHALL be compiled in per REQ-017/018.
REQ-024 Without HALF_ADDER_STATS_EN, carry_count SHALL be tied to 16'h0000, stat_clr SHALL be ignored, and no counter flops SHALL be generated; sum, carry and out_valid behaviour is identical in both builds.

Verification
REQ-025 Truth table, WIDTH=1: apply (a,b)=00,01,10,11 with in_valid=1, one per 10-cycle step -> one cycle later (sum,carry)=00,10,10,01, with out_valid=1 each time.
REQ-026 Hold: valid 11 then in_valid=0 with a=0, b=1 -> sum=0, carry=1 persist; out_valid=0.
REQ-027 Multi-lane, WIDTH=4: a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000.
REQ-028 Reset: rst=1 during valid 11 -> after the edge sum=0, carry=0, out_valid=0, carry_count=0.
REQ-029 Stats (macro defined): 3 valid 11 inputs and 2 valid 01 inputs -> carry_count=3; stat_clr together with a valid 11 -> carry_count=0; forced 65535 carry ops -> stays 16'hFFFF on the next one.
REQ-030 Stats (macro undefined): same stimulus as REQ-029 -> carry_count remains 0 throughout.
